// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer: FSM state encoding,
// oversampling constants and the baud divider helper.
package uart_rx_buffer_pkg;

   typedef logic [2:0] state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

   function automatic int calc_div(input int clk_freq, input int baud);
      int d;
      d = clk_freq / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receive-side bundle: serial line in, FWFT byte stream and sticky flags out.
// master = receiver/buffer, slave = byte consumer that also owns the line stimulus.
interface uart_rx_buffer_if #(parameter int FIFO_DEPTH = 16);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rxd;
   logic          rd_en;
   logic          clr_err;
   logic [7:0]    rd_data;
   logic          data_valid;
   logic          fifo_full;
   logic [CW-1:0] count;
   logic          frame_err;
   logic          overrun_err;

   modport master (
      input  rxd, rd_en, clr_err,
      output rd_data, data_valid, fifo_full, count, frame_err, overrun_err
   );

   modport slave (
      output rxd, rd_en, clr_err,
      input  rd_data, data_valid, fifo_full, count, frame_err, overrun_err
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head byte is visible while non-empty.
module uart_rx_fifo
   import uart_rx_buffer_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_push,
   input  logic [7:0]                  i_data,
   input  logic                        i_pop,
   output logic [7:0]                  o_data,
   output logic                        o_valid,
   output logic                        o_full,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_wr;

   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop     = i_pop && o_valid;
   // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
   assign w_wr      = i_push && (!o_full || w_pop);
   assign o_overrun = i_push && o_full && !i_pop;
   assign o_data    = o_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver (16x oversampled, 8 data bits, LSB first) feeding a FWFT FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   uart_rx_buffer_if.master bus
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int TW  = $clog2(DIV + 1);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
   localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
   localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

   logic          r_rxd_s1;
   logic          r_rxd_s2;
   logic [1:0]    r_sync_fill;
   logic          r_line_hi;
   logic [TW-1:0] r_tick_cnt;
   logic [3:0]    r_os_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   state_t        r_state;
   logic          r_frame_err;
   logic          r_overrun_err;

   logic          w_tick;
   logic          w_start;
   logic          w_mid;
   logic          w_bit_end;
   logic          w_stop_bad;
   logic          w_push;
   logic          w_frame_set;
   logic          w_overrun;
   logic [CW-1:0] w_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rxd_s1    <= 1'b1;
         r_rxd_s2    <= 1'b1;
         r_sync_fill <= 2'b00;
         r_line_hi   <= 1'b0;
      end else begin
         r_rxd_s1    <= bus.rxd;
         r_rxd_s2    <= r_rxd_s1;
         r_sync_fill <= {r_sync_fill[0], 1'b1};
         // Only trust the line once real samples have replaced the reset ones.
         r_line_hi   <= r_sync_fill[1] & r_rxd_s2;
      end
   end

   assign w_tick    = (r_tick_cnt == TW'(DIV - 1));
   assign w_start   = (r_state == ST_IDLE) && r_sync_fill[1] && r_line_hi && !r_rxd_s2;
   assign w_mid     = w_tick && (r_os_cnt == 4'(MID_SAMPLE));
   assign w_bit_end = w_tick && (r_os_cnt == 4'(OVERSAMPLE - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start || w_tick) r_tick_cnt <= '0;
      else                            r_tick_cnt <= r_tick_cnt + TW'(1);
   end

   // START counts to mid-bit, later states count full bit periods from there.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start || (r_state == ST_START && w_mid)) r_os_cnt <= '0;
      else if (w_tick && r_state != ST_IDLE)                 r_os_cnt <= r_os_cnt + 4'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_start) r_state <= ST_START;
            ST_START: if (w_mid) begin
               r_bit_cnt <= '0;
               r_state   <= r_rxd_s2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA:  if (w_bit_end) begin
               r_shift   <= {r_rxd_s2, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) r_state <= ST_AFTER_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (w_bit_end) r_state <= ST_STOP;
`endif
            ST_STOP:  if (w_bit_end) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_err;

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start)                          r_par_err <= 1'b0;
      else if (r_state == ST_PARITY && w_bit_end)    r_par_err <= (r_rxd_s2 != ^r_shift);
   end

   assign w_stop_bad = !r_rxd_s2 || r_par_err;
`else
   assign w_stop_bad = !r_rxd_s2;
`endif

   assign w_push      = (r_state == ST_STOP) && w_bit_end && !w_stop_bad;
   assign w_frame_set = (r_state == ST_STOP) && w_bit_end && w_stop_bad;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_frame_err   <= w_frame_set || (r_frame_err && !bus.clr_err);
         r_overrun_err <= w_overrun   || (r_overrun_err && !bus.clr_err);
      end
   end

   uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (w_push),
      .i_data    (r_shift),
      .i_pop     (bus.rd_en),
      .o_data    (bus.rd_data),
      .o_valid   (bus.data_valid),
      .o_full    (bus.fifo_full),
      .o_count   (w_count),
      .o_overrun (w_overrun)
   );

   assign bus.count       = w_count;
   assign bus.frame_err   = r_frame_err;
   assign bus.overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer at 16 clocks/bit, FIFO_DEPTH=4.
// Follows UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_buffer;
   import uart_rx_buffer_pkg::*;

   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // 2 sync clocks + 1 to enter START + 8 to mid-start, then 16 per remaining bit.
   localparam int LAT = 11 + 16 * (NBITS - 1);

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];
   vec_t       vecs[5];
   int         lat;

   always #5 clk = ~clk;

   uart_rx_buffer_if #(.FIFO_DEPTH(DEPTH)) bus();

   uart_rx_buffer #(
      .CLK_FREQ   (1600000),
      .BAUD       (100000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic idle(input int n);
      bus.rxd = 1'b1;
      repeat (n) tick();
   endtask

   task automatic pop_check(input string nm);
      logic [7:0] e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: read requested with no byte expected", nm);
         return;
      end
      e = sb.pop_front();
      check({nm, "_valid"}, int'(bus.data_valid), 1);
      check(nm, int'(bus.rd_data), int'(e));
   endtask

   task automatic read_one(input string nm);
      pop_check(nm);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   // Drives one frame; pop_at>0 raises rd_en for the clock after that many edges.
   task automatic send(input logic [7:0] d, input logic stop, input logic bad_par,
                       input int pop_at, output int lat_o);
      logic [NBITS-1:0] bits;
      int n;
      logic v0;
      n     = 0;
      lat_o = -1;
      v0    = bus.data_valid;
`ifdef UART_RX_PARITY_EN
      bits = {stop, (^d) ^ bad_par, d, 1'b0};
`else
      bits = {stop, d, 1'b0};
      if (bad_par) bits[0] = 1'b0;
`endif
      for (int b = 0; b < NBITS; b++) begin
         bus.rxd = bits[b];
         for (int k = 0; k < 16; k++) begin
            tick();
            n++;
            if (lat_o < 0 && !v0 && bus.data_valid) lat_o = n;
            bus.rd_en = 1'b0;
            if (n == pop_at) begin
               pop_check("pop_in_push_clk");
               bus.rd_en = 1'b1;
            end
         end
      end
      bus.rd_en = 1'b0;
      bus.rxd   = 1'b1;
   endtask

   initial begin
      vecs[0] = '{data: 8'h3C, stop: 1'b0, exp_ferr: 1'b1};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b0};
      vecs[3] = '{data: 8'h81, stop: 1'b1, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h5A, stop: 1'b0, exp_ferr: 1'b1};

      bus.rxd = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_valid",   int'(bus.data_valid),  0);
      check("rst_full",    int'(bus.fifo_full),   0);
      check("rst_count",   int'(bus.count),       0);
      check("rst_rd_data", int'(bus.rd_data),     0);
      check("rst_ferr",    int'(bus.frame_err),   0);
      check("rst_ovr",     int'(bus.overrun_err), 0);
      check("rst_state",   int'(dut.r_state),     int'(ST_IDLE));
      rst = 1'b0;
      idle(30);

      // single byte, exact arrival clock
      send(8'hA5, 1'b1, 1'b0, 0, lat);
      sb.push_back(8'hA5);
      check("a5_latency", lat, LAT);
      read_one("a5_read");
      check("a5_valid_after_pop", int'(bus.data_valid), 0);
      check("a5_count_after_pop", int'(bus.count), 0);
      idle(20);

      // 3-clock glitch must be rejected at the start mid-sample
      bus.rxd = 1'b0;
      repeat (3) tick();
      idle(40);
      check("glitch_state", int'(dut.r_state),   int'(ST_IDLE));
      check("glitch_valid", int'(bus.data_valid), 0);
      check("glitch_ferr",  int'(bus.frame_err),  0);
      check("glitch_ovr",   int'(bus.overrun_err), 0);

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].data, vecs[i].stop, 1'b0, 0, lat);
         if (vecs[i].stop) sb.push_back(vecs[i].data);
         idle(20);
         check($sformatf("vec%0d_ferr", i),  int'(bus.frame_err), int'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_count", i), int'(bus.count), sb.size());
         while (sb.size() > 0) read_one($sformatf("vec%0d_read", i));
         bus.clr_err = 1'b1;
         tick();
         bus.clr_err = 1'b0;
         check($sformatf("vec%0d_ferr_clr", i), int'(bus.frame_err), 0);
      end

      // fill, then overrun on the fifth byte
      for (int d = 1; d <= 5; d++) begin
         send(8'(d), 1'b1, 1'b0, 0, lat);
         if (d <= DEPTH) sb.push_back(8'(d));
         idle(20);
         if (d == DEPTH) begin
            check("fill_full",  int'(bus.fifo_full),   1);
            check("fill_count", int'(bus.count),       DEPTH);
            check("fill_ovr",   int'(bus.overrun_err), 0);
         end
      end
      check("ovr_flag",  int'(bus.overrun_err), 1);
      check("ovr_count", int'(bus.count),       DEPTH);
      for (int k = 0; k < DEPTH; k++) read_one($sformatf("ovr_read%0d", k));
      check("ovr_drained", int'(bus.data_valid), 0);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      check("ovr_clr", int'(bus.overrun_err), 0);

      // full FIFO, pop in the same clock as the push of 0x77
      for (int d = 0; d < DEPTH; d++) begin
         send(8'h10 + 8'(d), 1'b1, 1'b0, 0, lat);
         sb.push_back(8'h10 + 8'(d));
         idle(20);
      end
      send(8'h77, 1'b1, 1'b0, LAT - 1, lat);
      sb.push_back(8'h77);
      idle(20);
      check("sim_count", int'(bus.count),       DEPTH);
      check("sim_full",  int'(bus.fifo_full),   1);
      check("sim_ovr",   int'(bus.overrun_err), 0);
      for (int k = 0; k < DEPTH; k++) read_one($sformatf("sim_read%0d", k));

      // reset in the middle of 0xFF data bits
      bus.rxd = 1'b0;
      repeat (16) tick();
      bus.rxd = 1'b1;
      repeat (40) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      idle(40);
      check("midrst_state", int'(dut.r_state),   int'(ST_IDLE));
      check("midrst_count", int'(bus.count),     0);
      send(8'h12, 1'b1, 1'b0, 0, lat);
      sb.push_back(8'h12);
      idle(20);
      check("midrst_count_after", int'(bus.count),       1);
      check("midrst_ferr",        int'(bus.frame_err),   0);
      check("midrst_ovr",         int'(bus.overrun_err), 0);
      read_one("midrst_read");

`ifdef UART_RX_PARITY_EN
      send(8'h12, 1'b1, 1'b1, 0, lat);
      idle(20);
      check("par_ferr",  int'(bus.frame_err), 1);
      check("par_count", int'(bus.count),     0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
